// File: rtl/key_debounce.sv
// N-channel button front end: 2-FF sync, stable-time debounce, press pulses and a one-hot latest-press register.
// Define KEY_DEBOUNCE_INVERT_EN for active-low pads (btn_in inverted ahead of the synchroniser).
module key_debounce #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_db,
    output logic [N-1:0] btn_rise,
    output logic [N-1:0] onehot,
    output logic         valid
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     pad;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     accept;
    logic [N-1:0]     new_rise;
    logic [N-1:0]     first_rise;
    logic [CNT_W-1:0] cnt [N];

`ifdef KEY_DEBOUNCE_INVERT_EN
    // Sync stages reset to 0 = released, so an idle high pad never looks like a press.
    assign pad = ~btn_in;
`else
    assign pad = btn_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = (sync2[i] != btn_db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // An accepted change towards 1 is a press; isolate the lowest-index one for onehot.
    assign new_rise   = accept & sync2;
    assign first_rise = new_rise & (~new_rise + N'(1));

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || sync2[i] == btn_db[i] || accept[i]) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= '0;
            btn_rise <= '0;
            onehot   <= '0;
            valid    <= 1'b0;
        end else begin
            btn_db   <= btn_db ^ accept;
            btn_rise <= new_rise;
            if (|new_rise) begin
                onehot <= first_rise;
                valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (N=4, DEBOUNCE_CYCLES=8): directed scenarios plus
// randomized bursts checked against a sample-window reference model.
module tb_key_debounce;

    localparam int N = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_rise;
    logic [N-1:0] onehot;
    logic         valid;

    int checks = 0;
    int errors = 0;

    key_debounce #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .onehot   (onehot),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    // Logical "pressed" pattern to pad level.
    function automatic logic [N-1:0] pad(input logic [N-1:0] x);
`ifdef KEY_DEBOUNCE_INVERT_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    // Reference model: the level seen by the debouncer is the pressed level delayed by two
    // clocks; a channel adopts a new level once the last D such samples all disagree with it.
    logic [N-1:0] m_p1, m_p2, m_db, m_rise, m_oh, m_rises;
    logic         m_valid;
    logic [D-1:0] m_win [N];
    int           m_seen [N];

    always @(posedge clk) begin
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_db = '0; m_rise = '0; m_oh = '0; m_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_win[i]  = '0;
                m_seen[i] = 0;
            end
        end else begin
            m_rises = '0;
            for (int i = 0; i < N; i++) begin
                m_win[i] = {m_win[i][D-2:0], m_p2[i]};
                if (m_seen[i] < D) m_seen[i]++;
                if (m_seen[i] == D && (m_db[i] ? (m_win[i] == '0) : (m_win[i] == '1))) begin
                    if (!m_db[i]) m_rises[i] = 1'b1;
                    m_db[i] = ~m_db[i];
                end
            end
            m_rise = m_rises;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_rises[i]) begin
                    m_oh    = '0;
                    m_oh[i] = 1'b1;
                    m_valid = 1'b1;
                end
            end
            m_p2 = m_p1;
            m_p1 = pad(btn_in);
`ifdef KEY_DEBOUNCE_INVERT_EN
            m_p1 = ~btn_in;
`endif
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({btn_db, btn_rise, onehot, valid} !== 13'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got db=%b rise=%b oh=%b v=%b expected all 0", c, btn_db, btn_rise, onehot, valid);
            end
        end
        btn_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({btn_db, btn_rise, onehot, valid} !== 13'd0) begin
                errors++;
                $display("FAIL reset_held c=%0d got db=%b rise=%b oh=%b v=%b expected all 0", c, btn_db, btn_rise, onehot, valid);
            end
        end
        btn_in = pad(4'b0000);
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if ({btn_db, btn_rise, onehot, valid} !== 13'd0) begin
                errors++;
                $display("FAIL reset_release c=%0d got db=%b rise=%b oh=%b v=%b expected all 0", c, btn_db, btn_rise, onehot, valid);
            end
        end
    endtask

    task automatic test_clean_press();
        btn_in = pad(4'b0001);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== ((c == 10) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL press_rise c=%0d got %b expected %b", c, btn_rise, (c == 10) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (btn_db[0] !== (c >= 10)) begin
                errors++;
                $display("FAIL press_db c=%0d got %b expected %b", c, btn_db[0], c >= 10);
            end
        end
        checks++;
        if (onehot !== 4'b0001 || valid !== 1'b1) begin
            errors++;
            $display("FAIL press_onehot got oh=%b v=%b expected oh=0001 v=1", onehot, valid);
        end
    endtask

    task automatic test_simultaneous();
        btn_in = pad(4'b0000);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== 4'b0000 || btn_db[0] !== (c < 10)) begin
                errors++;
                $display("FAIL fall0 c=%0d got rise=%b db=%b", c, btn_rise, btn_db);
            end
        end
        btn_in = pad(4'b1010);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== ((c == 10) ? 4'b1010 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_rise c=%0d got %b expected %b", c, btn_rise, (c == 10) ? 4'b1010 : 4'b0000);
            end
        end
        checks++;
        if (onehot !== 4'b0010 || btn_db !== 4'b1010) begin
            errors++;
            $display("FAIL simul_onehot got oh=%b db=%b expected oh=0010 db=1010", onehot, btn_db);
        end
    endtask

    task automatic test_release();
        btn_in = pad(4'b0100);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== ((c == 10) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL rel_press c=%0d got %b", c, btn_rise);
            end
        end
        btn_in = pad(4'b0000);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== 4'b0000 || btn_db[2] !== (c < 10)) begin
                errors++;
                $display("FAIL release c=%0d got rise=%b db=%b expected rise=0000 db2=%b", c, btn_rise, btn_db, c < 10);
            end
        end
        checks++;
        if (onehot !== 4'b0100 || valid !== 1'b1) begin
            errors++;
            $display("FAIL release_hold got oh=%b v=%b expected oh=0100 v=1", onehot, valid);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            btn_in = pad((k % 2 == 0) ? 4'b0010 : 4'b0000);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if (btn_rise !== 4'b0000) begin
                    errors++;
                    $display("FAIL bounce_quiet k=%0d got rise=%b expected 0000", k, btn_rise);
                end
            end
        end
        btn_in = pad(4'b0010);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== ((c == 10) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL bounce_rise c=%0d got %b expected %b", c, btn_rise, (c == 10) ? 4'b0010 : 4'b0000);
            end
        end
        checks++;
        if (onehot !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_onehot got %b expected 0010", onehot);
        end
    endtask

    task automatic test_held_across_reset();
        rst = 1'b1;
        btn_in = pad(4'b0001);
        for (int c = 0; c < 3; c++) @(negedge clk);
        checks++;
        if ({btn_db, btn_rise, onehot, valid} !== 13'd0) begin
            errors++;
            $display("FAIL held_rst got db=%b oh=%b v=%b expected all 0", btn_db, onehot, valid);
        end
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (btn_rise !== ((c == D + 2) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL held_rise c=%0d got %b expected %b", c, btn_rise, (c == D + 2) ? 4'b0001 : 4'b0000);
            end
        end
        checks++;
        if (onehot !== 4'b0001 || valid !== 1'b1) begin
            errors++;
            $display("FAIL held_onehot got oh=%b v=%b expected oh=0001 v=1", onehot, valid);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 70; s++) begin
            int len;
            len = int'($urandom_range(1, 14));
            rst = ($urandom_range(0, 11) == 0);
            btn_in = 4'($urandom);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({btn_db, btn_rise, onehot, valid} !== {m_db, m_rise, m_oh, m_valid}) begin
                    errors++;
                    $display("FAIL random_model s=%0d c=%0d got db=%b rise=%b oh=%b v=%b expected db=%b rise=%b oh=%b v=%b",
                             s, c, btn_db, btn_rise, onehot, valid, m_db, m_rise, m_oh, m_valid);
                end
                checks++;
                if (onehot != 0 && (onehot & (onehot - 4'd1)) != 0) begin
                    errors++;
                    $display("FAIL random_onehot got %b expected at most one bit", onehot);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_in = '0;
        test_reset();
        test_clean_press();
        test_simultaneous();
        test_release();
        test_bounce();
        test_held_across_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
